// File: rtl/axi_pkg.sv
// AXI4 encodings and the write-buffer master state type.
// No ports; provides burst/response constants and wb_state_t.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_B
  } wb_state_t;

endpackage

// File: rtl/core_config.sv
// Core-wide configuration constants shared by the cache and bus blocks.
// No ports; import or reference core_config::LINE_WIDTH for the cacheline size.
package core_config;

  localparam int LINE_WIDTH = 128;

endpackage

// File: rtl/dcache_axi_wb_master.sv
// Drain side of the dcache write-buffer FIFO: takes one dirty line plus its
// address per handshake and writes it out as a single AXI4 INCR burst
// (AW, BEATS x W, then B). Only one burst is ever outstanding.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   FIFO side : wen_i, awaddr_i, wdata_i in; ready_o out (FIFO pops on it)
//   AXI AW    : awvalid_o, awready_i, awaddr_o, awlen_o, awsize_o, awburst_o, awid_o
//   AXI W     : wvalid_o, wready_i, wdata_o, wstrb_o, wlast_o
//   AXI B     : bvalid_i, bready_o, bresp_i, bid_i
//   err_o     : sticky write-error flag
//
// Build option: define DCACHE_AXI_WB_BRESP_CHECK_EN to make err_o latch any
// non-OKAY write response until reset; otherwise err_o is tied to 0.
module dcache_axi_wb_master
  import axi_pkg::*;
#(
  parameter int                  LINE_WIDTH     = core_config::LINE_WIDTH,
  parameter int                  AXI_DATA_WIDTH = 32,
  parameter int                  ID_WIDTH       = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID         = 4'h1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wen_i,
  input  logic [31:0]                 awaddr_i,
  input  logic [LINE_WIDTH-1:0]       wdata_i,
  output logic                        ready_o,
  output logic                        awvalid_o,
  input  logic                        awready_i,
  output logic [31:0]                 awaddr_o,
  output logic [7:0]                  awlen_o,
  output logic [2:0]                  awsize_o,
  output logic [1:0]                  awburst_o,
  output logic [ID_WIDTH-1:0]         awid_o,
  output logic                        wvalid_o,
  input  logic                        wready_i,
  output logic [AXI_DATA_WIDTH-1:0]   wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] wstrb_o,
  output logic                        wlast_o,
  input  logic                        bvalid_i,
  output logic                        bready_o,
  input  logic [1:0]                  bresp_i,
  input  logic [ID_WIDTH-1:0]         bid_i,
  output logic                        err_o
);

  localparam int BEATS  = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  // Clears the byte offset within the line so the burst starts line-aligned.
  localparam logic [31:0] LINE_MASK = ~32'(LINE_WIDTH / 8 - 1);

  wb_state_t state_q, state_d;

  logic                  aw_done_q;
  logic                  w_done_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [31:0]           addr_q;
  logic [LINE_WIDTH-1:0] line_q;

  logic [BEATS-1:0][AXI_DATA_WIDTH-1:0] beat_words;

  logic accept;
  logic aw_fire;
  logic w_fire;
  logic w_last_fire;

  assign ready_o   = (state_q == IDLE);
  assign awvalid_o = (state_q == SEND) && !aw_done_q;
  // w_done_q keeps wvalid low once all beats are out while AW is still pending.
  assign wvalid_o  = (state_q == SEND) && !w_done_q;
  assign bready_o  = (state_q == WAIT_B);

  assign accept      = wen_i && ready_o;
  assign aw_fire     = awvalid_o && awready_i;
  assign w_fire      = wvalid_o && wready_i;
  assign w_last_fire = w_fire && (beat_q == LAST_BEAT);

  assign beat_words = line_q;
  assign wdata_o    = beat_words[beat_q];
  assign wlast_o    = wvalid_o && (beat_q == LAST_BEAT);
  assign awaddr_o   = addr_q;

  assign awlen_o   = 8'(BEATS - 1);
  assign awsize_o  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign awburst_o = AXI_BURST_INCR;
  assign awid_o    = AXI_ID;
  assign wstrb_o   = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      // AW and W complete independently; leave once both have finished,
      // counting a handshake that lands in this very cycle.
      SEND:    if ((aw_done_q || aw_fire) && (w_done_q || w_last_fire)) state_d = WAIT_B;
      WAIT_B:  if (bvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      beat_q    <= '0;
      addr_q    <= '0;
      line_q    <= '0;
    end else if (accept) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      beat_q    <= '0;
      addr_q    <= awaddr_i & LINE_MASK;
      line_q    <= wdata_i;
    end else begin
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_last_fire) begin
        w_done_q <= 1'b1;
        beat_q   <= '0;
      end else if (w_fire) begin
        beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

`ifdef DCACHE_AXI_WB_BRESP_CHECK_EN
  logic err_q;
  logic b_fire;

  assign b_fire = bvalid_i && bready_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (b_fire && (bresp_i != AXI_RESP_OKAY)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // The response ID is never checked, and bresp_i only matters with the error check.
  logic unused_b;
  assign unused_b = ^{bid_i, bresp_i};

endmodule

// File: tb/tb_dcache_axi_wb_master.sv
module tb_dcache_axi_wb_master;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wen_i = 1'b0;
  logic [31:0]  awaddr_i = '0;
  logic [127:0] wdata_i = '0;
  logic         ready_o;
  logic         awvalid_o;
  logic         awready_i = 1'b1;
  logic [31:0]  awaddr_o;
  logic [7:0]   awlen_o;
  logic [2:0]   awsize_o;
  logic [1:0]   awburst_o;
  logic [3:0]   awid_o;
  logic         wvalid_o;
  logic         wready_i = 1'b1;
  logic [31:0]  wdata_o;
  logic [3:0]   wstrb_o;
  logic         wlast_o;
  logic         bvalid_i = 1'b0;
  logic         bready_o;
  logic [1:0]   bresp_i = 2'b00;
  logic [3:0]   bid_i = 4'h1;
  logic         err_o;

`ifdef DCACHE_AXI_WB_BRESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  dcache_axi_wb_master dut (
    .clk       (clk),
    .rst       (rst),
    .wen_i     (wen_i),
    .awaddr_i  (awaddr_i),
    .wdata_i   (wdata_i),
    .ready_o   (ready_o),
    .awvalid_o (awvalid_o),
    .awready_i (awready_i),
    .awaddr_o  (awaddr_o),
    .awlen_o   (awlen_o),
    .awsize_o  (awsize_o),
    .awburst_o (awburst_o),
    .awid_o    (awid_o),
    .wvalid_o  (wvalid_o),
    .wready_i  (wready_i),
    .wdata_o   (wdata_o),
    .wstrb_o   (wstrb_o),
    .wlast_o   (wlast_o),
    .bvalid_i  (bvalid_i),
    .bready_o  (bready_o),
    .bresp_i   (bresp_i),
    .bid_i     (bid_i),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard queues: expected AW addresses and expected W beats {last, data}.
  logic [31:0] aq[$];
  logic [32:0] wq[$];

  // Slave configuration, written only by the stimulus process.
  int         aw_stall_cfg = 0;
  logic       w_toggle     = 1'b0;
  logic [1:0] bresp_cfg    = 2'b00;

  // Slave/monitor state, written only by the monitor process.
  int          aw_wait = 0;
  logic        tog = 1'b1;
  logic        got_aw = 1'b0;
  int          w_cnt = 0;
  int          w_total = 0;
  int          w_at_aw = 0;
  logic        bready_seen = 1'b0;
  logic        aw_hold = 1'b0;
  logic        w_hold = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [31:0] hold_data = '0;
  logic        hold_last = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm, input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %s (t=%0t)", nm, what, $time);
  endtask

  // Monitor and AXI slave. Readies are chosen first, then the handshake that
  // the DUT will register at the next rising edge is checked.
  always @(negedge clk) begin
    if (!rst) begin
      awready_i   = 1'b1;
      wready_i    = 1'b1;
      bvalid_i    = 1'b0;
      aw_wait     = 0;
      tog         = 1'b1;
      got_aw      = 1'b0;
      w_cnt       = 0;
      bready_seen = 1'b0;
      aw_hold     = 1'b0;
      w_hold      = 1'b0;
    end else begin
      awready_i = !(awvalid_o && (aw_wait < aw_stall_cfg));
      if (awvalid_o && !awready_i) aw_wait++;
      wready_i = w_toggle ? tog : 1'b1;
      if (wvalid_o) tog = ~tog;
      bvalid_i = got_aw && (w_cnt == 4);
      bresp_i  = bresp_cfg;

      if (aw_hold) begin
        chk("aw_hold_valid", 128'(awvalid_o), 128'(1'b1));
        chk("aw_hold_addr", 128'(awaddr_o), 128'(hold_addr));
      end
      if (w_hold) begin
        chk("w_hold_valid", 128'(wvalid_o), 128'(1'b1));
        chk("w_hold_data", 128'(wdata_o), 128'(hold_data));
        chk("w_hold_last", 128'(wlast_o), 128'(hold_last));
      end
      if (bready_o && !bready_seen) begin
        chk("bready_after_aw", 128'(got_aw), 128'(1'b1));
        bready_seen = 1'b1;
      end

      if (awvalid_o && awready_i) begin
        if (aq.size() == 0) begin
          fail_now("aw_unexpected", "AW handshake with no line outstanding");
        end else begin
          chk("awaddr", 128'(awaddr_o), 128'(aq.pop_front()));
          chk("awlen", 128'(awlen_o), 128'(8'd3));
          chk("awsize", 128'(awsize_o), 128'(3'd2));
          chk("awburst", 128'(awburst_o), 128'(2'b01));
          chk("awid", 128'(awid_o), 128'(4'h1));
        end
        got_aw  = 1'b1;
        w_at_aw = w_cnt;
        aw_wait = 0;
      end

      if (wvalid_o && wready_i) begin
        if (wq.size() == 0) begin
          fail_now("w_unexpected", "W handshake with no beat outstanding");
        end else begin
          logic [32:0] ew;
          ew = wq.pop_front();
          chk("wdata", 128'(wdata_o), 128'(ew[31:0]));
          chk("wlast", 128'(wlast_o), 128'(ew[32]));
          chk("wstrb", 128'(wstrb_o), 128'(4'hF));
        end
        w_cnt++;
        w_total++;
      end

      if (bvalid_i && bready_o) begin
        got_aw      = 1'b0;
        w_cnt       = 0;
        tog         = 1'b1;
        bready_seen = 1'b0;
      end

      aw_hold   = awvalid_o && !awready_i;
      hold_addr = awaddr_o;
      w_hold    = wvalid_o && !wready_i;
      hold_data = wdata_o;
      hold_last = wlast_o;
    end
  end

  // Present a line on the FIFO side (at a negedge) and push its expectations.
  task automatic issue(input logic [31:0] a, input logic [127:0] d, input logic [31:0] ea);
    logic [127:0] dd;
    dd       = d;
    wen_i    = 1'b1;
    awaddr_i = a;
    wdata_i  = d;
    aq.push_back(ea);
    for (int i = 0; i < 4; i++) wq.push_back({(i == 3), dd[i*32 +: 32]});
  endtask

  task automatic send_line(input logic [31:0] a, input logic [127:0] d, input logic [31:0] ea);
    issue(a, d, ea);
    @(negedge clk);
    wen_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!(ready_o && aq.size() == 0 && wq.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(ready_o && aq.size() == 0 && wq.size() == 0))
      fail_now(nm, "timeout waiting for burst completion");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int w_before;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(ready_o), 128'(1'b1));
    chk("rst_awvalid", 128'(awvalid_o), 128'(1'b0));
    chk("rst_wvalid", 128'(wvalid_o), 128'(1'b0));
    chk("rst_bready", 128'(bready_o), 128'(1'b0));
    chk("rst_wlast", 128'(wlast_o), 128'(1'b0));
    chk("rst_awaddr", 128'(awaddr_o), 128'(32'h0));
    chk("rst_wdata", 128'(wdata_o), 128'(32'h0));
    chk("rst_err", 128'(err_o), 128'(1'b0));
    #2 rst = 1'b1;
    @(negedge clk);

    // All readies high: latency and beat order
    issue(32'h1000_0024, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 32'h1000_0020);
    @(negedge clk);
    wen_i = 1'b0;
    chk("t1_ready_busy", 128'(ready_o), 128'(1'b0));
    n = 1;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_ready_latency", 128'(n), 128'(6));
    wait_idle("t1_idle");

    // AW held off for 5 cycles: all W beats go first
    aw_stall_cfg = 5;
    send_line(32'h2000_0008, 128'hAAAA_0004_AAAA_0003_AAAA_0002_AAAA_0001, 32'h2000_0000);
    wait_idle("t2_idle");
    chk("t2_w_before_aw", 128'(w_at_aw), 128'(4));
    aw_stall_cfg = 0;

    // wready toggling
    w_toggle = 1'b1;
    w_before = w_total;
    send_line(32'h3000_0010, 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF, 32'h3000_0010);
    wait_idle("t3_idle");
    chk("t3_w_handshakes", 128'(w_total - w_before), 128'(4));
    w_toggle = 1'b0;

    // wen held high through the burst: second line only after B
    issue(32'h4000_0000, 128'h0000_000D_0000_000C_0000_000B_0000_000A, 32'h4000_0000);
    @(negedge clk);
    chk("t4_ready_busy", 128'(ready_o), 128'(1'b0));
    issue(32'h4000_0030, 128'h1000_000D_1000_000C_1000_000B_1000_000A, 32'h4000_0030);
    n = 1;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_no_early_accept", 128'(n), 128'(6));
    @(negedge clk);
    wen_i = 1'b0;
    chk("t4_second_accepted", 128'(ready_o), 128'(1'b0));
    wait_idle("t4_idle");

    // Asynchronous reset in the middle of the burst (beat 2 on the bus)
    aw_stall_cfg = 10;
    send_line(32'h5000_0040, 128'h5555_0003_5555_0002_5555_0001_5555_0000, 32'h5000_0040);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t5_pre_beat2", 128'(wdata_o), 128'(32'h5555_0002));
    chk("t5_pre_awvalid", 128'(awvalid_o), 128'(1'b1));
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_awvalid", 128'(awvalid_o), 128'(1'b0));
    chk("t5_rst_wvalid", 128'(wvalid_o), 128'(1'b0));
    chk("t5_rst_bready", 128'(bready_o), 128'(1'b0));
    chk("t5_rst_ready", 128'(ready_o), 128'(1'b1));
    chk("t5_rst_wlast", 128'(wlast_o), 128'(1'b0));
    chk("t5_rst_awaddr", 128'(awaddr_o), 128'(32'h0));
    chk("t5_rst_wdata", 128'(wdata_o), 128'(32'h0));
    aq.delete();
    wq.delete();
    aw_stall_cfg = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    send_line(32'h5100_0000, 128'h6666_0003_6666_0002_6666_0001_6666_0000, 32'h5100_0000);
    wait_idle("t5_idle");

    // Error response, then an OKAY burst
    bresp_cfg = 2'b10;
    send_line(32'h6000_0000, 128'h7777_0003_7777_0002_7777_0001_7777_0000, 32'h6000_0000);
    wait_idle("t6_idle_err");
    @(negedge clk);
    chk("t6_err_after_slverr", 128'(err_o), 128'(EXP_ERR));
    bresp_cfg = 2'b00;
    send_line(32'h6000_0010, 128'h8888_0003_8888_0002_8888_0001_8888_0000, 32'h6000_0010);
    wait_idle("t6_idle_ok");
    @(negedge clk);
    chk("t6_err_sticky", 128'(err_o), 128'(EXP_ERR));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_axi_wb_master.md
Name: dcache_axi_wb_master

Overview:
- Consumer end of the dcache write-buffer FIFO drain interface.
- Accepts one 128-bit dirty line plus its address per handshake and issues it as a single AXI4 INCR write burst: AW, then N W beats, then B.
- Signals readiness for the next line back to the FIFO; the FIFO pops its head on that signal.
- Sits between the dcache write FIFO and the core's AXI master arbiter.

Parameters:
- LINE_WIDTH, 128, cacheline width in bits.
- AXI_DATA_WIDTH, 32, AXI W-channel data width in bits.
- AXI_ID, 4'h1, constant AWID driven on every burst.
- ID_WIDTH, 4, AWID/BID width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
- wen_i  in  1  FIFO has a line to write (FIFO axi_wen_o).
- awaddr_i  in  32  line address (FIFO axi_awaddr_o).
- wdata_i  in  LINE_WIDTH  line data (FIFO axi_wdata_o).
- ready_o  out  1  idle, can accept a line (to FIFO axi_bvalid_i).
- awvalid_o  out  1  AXI AW valid.
- awready_i  in  1  AXI AW ready.
- awaddr_o  out  32  AXI AW address.
- awlen_o  out  8  AXI AW burst length.
- awsize_o  out  3  AXI AW beat size.
- awburst_o  out  2  AXI AW burst type.
- awid_o  out  ID_WIDTH  AXI AW ID.
- wvalid_o  out  1  AXI W valid.
- wready_i  in  1  AXI W ready.
- wdata_o  out  AXI_DATA_WIDTH  AXI W data.
- wstrb_o  out  AXI_DATA_WIDTH/8  AXI W strobes.
- wlast_o  out  1  AXI W last beat.
- bvalid_i  in  1  AXI B valid.
- bready_o  out  1  AXI B ready.
- bresp_i  in  2  AXI B response.
- bid_i  in  ID_WIDTH  AXI B ID.
- err_o  out  1  sticky write-error flag; exists only with the optional feature.

Behaviour:
- Derived values: BEATS = LINE_WIDTH/AXI_DATA_WIDTH (default 4); beat counter width $clog2(BEATS).
- FSM states:
  - IDLE: ready_o=1. Accept when wen_i && ready_o: latch {awaddr_i[31:4],4'h0} and wdata_i, clear aw_done, beat=0 → SEND. wen_i is ignored in every other state.
  - SEND: awvalid_o=!aw_done and wvalid_o=1, both asserted from the cycle after accept.
    - AW handshake (awvalid_o && awready_i) sets aw_done; awvalid_o drops the next cycle.
    - Each W handshake increments beat.
    - When aw_done (or the AW handshake this cycle) and the last W handshake are both complete → WAIT_B.
    - W beats may complete before AW; AW and W are independent.
  - WAIT_B: bready_o=1. On bvalid_i → IDLE. bid_i is not checked. ready_o reasserts in the cycle after the B handshake.
- Constant outputs: awlen_o=BEATS-1 (8'd3); awsize_o=$clog2(AXI_DATA_WIDTH/8) (3'd2); awburst_o=2'b01 (INCR); awid_o=AXI_ID; wstrb_o all ones.
- Beat data: wdata_o = line[beat*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]; beat 0 = bits [31:0] = lowest address. wlast_o=1 only when beat==BEATS-1.
- Holding rule: wdata_o and awaddr_o stay stable while the corresponding valid is high and ready is low (AXI rule).
- Latency, all readies high: accept at cycle t; AW + W0 at t+1; W3 at t+4; B earliest t+5; ready_o high at t+6. Maximum throughput is one line per 6 cycles.
- Reset (rst=0), including mid-burst: state → IDLE immediately (asynchronous).
  - Reset output values: ready_o=1; awvalid_o=0; wvalid_o=0; bready_o=0; wlast_o=0; beat=0; aw_done=0; awaddr_o=0; wdata_o=0; err_o=0.
  - The in-flight burst is abandoned (system-wide reset).
- Only one outstanding burst at a time; no write interleaving.

Optional Feature:
- Macro: DCACHE_AXI_WB_BRESP_CHECK_EN.
- Defined: err_o is set when a B handshake occurs with bresp_i != 2'b00 (SLVERR/DECERR) and holds until reset. FSM flow is unchanged; no retry.
- Undefined: err_o is tied to 0 and no error logic is built.

Decomposition:
- Shared package axi_pkg:
  - burst type constants: AXI_BURST_FIXED/INCR/WRAP;
  - response constants: AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - wb_state_t enum {IDLE, SEND, WAIT_B}.
- LINE_WIDTH default comes from core_config.
- No sub-module: the beat serializer is an indexed part-select and stays inline; the block is flat.

Test Plan:
- All readies high: wen_i=1, awaddr_i=32'h1000_0024, wdata_i=128'h4444_4444_3333_3333_2222_2222_1111_1111 → awaddr_o=32'h1000_0020, awlen_o=3, awsize_o=2; wdata beats 1111_1111, 2222_2222, 3333_3333, 4444_4444; wlast on beat 4; ready_o back at t+6.
- awready_i held low 5 cycles while wready_i=1 → all 4 W beats complete first; awvalid_o stays high with awaddr_o stable; bready_o only after the AW handshake.
- wready_i toggling 1,0,1,0 → wdata_o holds each beat across stall cycles; exactly 4 handshakes; wlast_o only on the 4th.
- wen_i=1 held during SEND and WAIT_B → no second accept; ready_o=0 until the cycle after the B handshake; the second line starts only then.
- rst=0 asserted during beat 2 → awvalid_o, wvalid_o, bready_o drop to 0 immediately; ready_o=1. After release, a new line bursts from beat 0.
- With DCACHE_AXI_WB_BRESP_CHECK_EN: bresp_i=2'b10 → err_o=1 and stays 1 across the next OKAY burst. Without the macro → err_o stays 0.
